// File: rtl/score_pkg.sv
// score_pkg: shared constants, conversion FSM state type and score clamp
// helper for the score digit renderer.
package score_pkg;

    localparam int DIGIT_W   = 4;   // one BCD digit
    localparam int LINE_W    = 4;   // glyph line index (16 lines)
    localparam int GLYPH_W   = 8;   // glyph width in pixels
    localparam int GLYPH_H   = 16;  // glyph height in pixels
    localparam int MAX_SCORE = 99;  // two decimal digits

    typedef enum logic [1:0] {
        IDLE,
        CONV_L,
        CONV_R,
        COMMIT
    } conv_state_t;

    // Scores above two digits are shown as 99 rather than wrapping.
    function automatic logic [6:0] clamp_score(input logic [6:0] s);
        return (s > 7'(MAX_SCORE)) ? 7'(MAX_SCORE) : s;
    endfunction

endpackage

// File: rtl/bin2dec_seq.sv
// bin2dec_seq: 7-bit binary (0..99) to tens/units by repeated subtraction.
//   clk, rst_n : clock, async active-low reset
//   start      : load value and begin (takes priority over an active run)
//   value      : binary input, must be <= 99
//   done       : combinational, high in the final cycle of a run; tens and
//                units are valid in that same cycle
//   tens/units : decimal result
// One subtraction per cycle, so a run takes tens+1 cycles.
module bin2dec_seq
    import score_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [6:0]         value,
    output logic               done,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] units
);

    logic [6:0]         rem;
    logic [DIGIT_W-1:0] tens_q;
    logic               active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem    <= '0;
            tens_q <= '0;
            active <= 1'b0;
        end else if (start) begin
            rem    <= value;
            tens_q <= '0;
            active <= 1'b1;
        end else if (active) begin
            if (rem >= 7'd10) begin
                rem    <= rem - 7'd10;
                tens_q <= tens_q + 1'b1;
            end else begin
                active <= 1'b0;
            end
        end
    end

    // Once rem drops below 10 it is the units digit.
    assign done  = active && (rem < 7'd10);
    assign tens  = tens_q;
    assign units = rem[DIGIT_W-1:0];

endmodule

// File: rtl/score_digit_renderer.sv
// score_digit_renderer: draws two 2-digit scores into the VGA pixel stream.
//   clk, rst_n              : pixel clock, async active-low reset
//   frame_start             : start-of-vblank pulse; latches scores in IDLE
//   score_left/score_right  : binary scores (clamped to 99)
//   pixel_x/pixel_y/video_on: timing generator position
//   rom_addr                : {digit, line} to the shared glyph ROM
//   rom_data                : glyph line, one cycle after rom_addr
//   pixel_on                : lit digit pixel, 2 cycles after pixel inputs
//   busy                    : decimal conversion in progress
module score_digit_renderer
    import score_pkg::*;
#(
    parameter int LEFT_X      = 256,
    parameter int RIGHT_X     = 352,
    parameter int TOP_Y       = 16,
    parameter int SCALE_SHIFT = 1,
    parameter int BLANK_LZ    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic [6:0] score_left,
    input  logic [6:0] score_right,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       pixel_on,
    output logic       busy
);

    localparam int COL_W = $clog2(GLYPH_W);

    // Geometry in 11 bits so cx+width never wraps at the right edge.
    localparam logic [10:0] CW   = 11'(GLYPH_W << SCALE_SHIFT);
    localparam logic [10:0] CH   = 11'(GLYPH_H << SCALE_SHIFT);
    localparam logic [10:0] LT_X = 11'(LEFT_X);
    localparam logic [10:0] LU_X = 11'(LEFT_X + (GLYPH_W << SCALE_SHIFT));
    localparam logic [10:0] RT_X = 11'(RIGHT_X);
    localparam logic [10:0] RU_X = 11'(RIGHT_X + (GLYPH_W << SCALE_SHIFT));
    localparam logic [10:0] Y0   = 11'(TOP_Y);

    // ---------------- conversion FSM ----------------
    conv_state_t        state;
    logic [6:0]         right_q;
    logic [DIGIT_W-1:0] wl_t, wl_u, wr_t, wr_u;   // working digits
    logic [DIGIT_W-1:0] dl_t, dl_u, dr_t, dr_u;   // displayed digits

    logic               div_start, div_done;
    logic [6:0]         div_value;
    logic [DIGIT_W-1:0] div_tens, div_units;

    // The divider starts on the frame_start edge with the left score, then
    // is restarted with the right score on the cycle the left one finishes.
    assign div_start = ((state == IDLE) && frame_start) ||
                       ((state == CONV_L) && div_done);
    assign div_value = (state == IDLE) ? clamp_score(score_left) : right_q;

    bin2dec_seq u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .value (div_value),
        .done  (div_done),
        .tens  (div_tens),
        .units (div_units)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            right_q <= '0;
            wl_t <= '0; wl_u <= '0; wr_t <= '0; wr_u <= '0;
            dl_t <= '0; dl_u <= '0; dr_t <= '0; dr_u <= '0;
        end else begin
            case (state)
                IDLE: if (frame_start) begin
                    right_q <= clamp_score(score_right);
                    state   <= CONV_L;
                    busy    <= 1'b1;
                end
                CONV_L: if (div_done) begin
                    wl_t  <= div_tens;
                    wl_u  <= div_units;
                    state <= CONV_R;
                end
                CONV_R: if (div_done) begin
                    wr_t  <= div_tens;
                    wr_u  <= div_units;
                    state <= COMMIT;
                end
                COMMIT: begin
                    // All four digits update together so a frame never
                    // shows a mix of old and new scores.
                    dl_t  <= wl_t; dl_u <= wl_u;
                    dr_t  <= wr_t; dr_u <= wr_u;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- stage 0: cell hit ----------------
    logic [10:0]        px, py;
    logic               in_y, hit_lt, hit_lu, hit_rt, hit_ru;
    logic               hit0, tens_cell, blank0;
    logic [9:0]         cx, dx, dy;
    logic [DIGIT_W-1:0] digit;
    logic [LINE_W-1:0]  line0;
    logic [COL_W-1:0]   col0;

    assign px     = {1'b0, pixel_x};
    assign py     = {1'b0, pixel_y};
    assign in_y   = video_on && (py >= Y0) && (py < Y0 + CH);
    assign hit_lt = in_y && (px >= LT_X) && (px < LT_X + CW);
    assign hit_lu = in_y && (px >= LU_X) && (px < LU_X + CW);
    assign hit_rt = in_y && (px >= RT_X) && (px < RT_X + CW);
    assign hit_ru = in_y && (px >= RU_X) && (px < RU_X + CW);

    always_comb begin
        hit0      = 1'b0;
        tens_cell = 1'b0;
        cx        = '0;
        digit     = '0;
        // Priority order resolves any overlap from odd parameter choices.
        if (hit_lt) begin
            hit0 = 1'b1; tens_cell = 1'b1; cx = LT_X[9:0]; digit = dl_t;
        end else if (hit_lu) begin
            hit0 = 1'b1; cx = LU_X[9:0]; digit = dl_u;
        end else if (hit_rt) begin
            hit0 = 1'b1; tens_cell = 1'b1; cx = RT_X[9:0]; digit = dr_t;
        end else if (hit_ru) begin
            hit0 = 1'b1; cx = RU_X[9:0]; digit = dr_u;
        end
        // Offsets are only used under hit0, where both are non-negative.
        dx       = pixel_x - cx;
        dy       = pixel_y - Y0[9:0];
        line0    = hit0 ? LINE_W'(dy >> SCALE_SHIFT) : '0;
        col0     = hit0 ? COL_W'(dx >> SCALE_SHIFT) : '0;
        rom_addr = hit0 ? {digit, line0} : 8'h00;
        blank0   = (BLANK_LZ != 0) && tens_cell && (digit == '0);
    end

    // ---------------- stages 1 and 2 ----------------
    logic             hit1, blank1;
    logic [COL_W-1:0] col1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit1     <= 1'b0;
            blank1   <= 1'b0;
            col1     <= '0;
            pixel_on <= 1'b0;
        end else begin
            hit1     <= hit0;
            blank1   <= blank0;
            col1     <= col0;
            // rom_data now holds the line addressed in stage 0; MSB is leftmost.
            pixel_on <= hit1 && !blank1 && rom_data[3'd7 - col1];
        end
    end

endmodule

// File: tb/tb_score_digit_renderer.sv
// tb_score_digit_renderer: directed checks of score conversion timing,
// clamping, blanking, cell geometry and pixel pipeline latency.
// The bench ROM returns 8'h6C at address 8'h03 and {line, digit} elsewhere,
// so lit pixels reveal the digit and line directly.
module tb_score_digit_renderer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic [6:0] score_left = '0, score_right = '0;
    logic [9:0] pixel_x = '0, pixel_y = '0;
    logic       video_on = 1'b1;
    logic [7:0] rom_addr, rom_data;
    logic       pixel_on, busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] a;
        logic       p;
    } vec_t;

    score_digit_renderer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .score_left  (score_left),
        .score_right (score_right),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .video_on    (video_on),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pixel_on    (pixel_on),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk)
        rom_data <= (rom_addr == 8'h03) ? 8'h6C : {rom_addr[3:0], rom_addr[7:4]};

    // Drive one pixel, read the address combinationally and pixel_on after
    // the two pipeline edges.
    task automatic probe(input logic [9:0] x, input logic [9:0] y,
                         output logic [7:0] a, output logic p);
        @(negedge clk);
        pixel_x = x; pixel_y = y;
        #1 a = rom_addr;
        @(posedge clk);
        @(posedge clk);
        #1 p = pixel_on;
    endtask

    task automatic pulse_frame(input logic [6:0] l, input logic [6:0] r);
        @(negedge clk);
        score_left = l; score_right = r; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic test_reset;
        vec_t v[5];
        logic [7:0] a;
        logic p;
        v = '{'{10'd274, 10'd22, 8'h03, 1'b1},   // left units '0', line 3 col 1
              '{10'd258, 10'd22, 8'h03, 1'b0},   // left tens blanked
              '{10'd370, 10'd22, 8'h03, 1'b1},   // right units '0'
              '{10'd354, 10'd22, 8'h03, 1'b0},   // right tens blanked
              '{10'd100, 10'd100, 8'h00, 1'b0}};
        #1;
        n_checks++;
        if (busy !== 1'b0 || pixel_on !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: busy=%b pixel_on=%b want 0 0", busy, pixel_on);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        foreach (v[i]) begin
            probe(v[i].x, v[i].y, a, p);
            n_checks++;
            if (a !== v[i].a || p !== v[i].p) begin
                n_fail++;
                $display("FAIL reset_vec%0d: addr=%h pon=%b want %h %b", i, a, p, v[i].a, v[i].p);
            end
        end
        // Streaming scan of lines just outside every cell edge.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 161; k++) begin
                @(negedge clk);
                case (r)
                    0: begin pixel_x = 10'(240 + k); pixel_y = 10'd15; end
                    1: begin pixel_x = 10'(240 + k); pixel_y = 10'd48; end
                    2: begin pixel_x = 10'd255; pixel_y = 10'(k % 64); end
                    3: begin pixel_x = 10'd288; pixel_y = 10'(k % 64); end
                    4: begin pixel_x = 10'd351; pixel_y = 10'(k % 64); end
                    default: begin pixel_x = 10'd384; pixel_y = 10'(k % 64); end
                endcase
                #1;
                n_checks++;
                if (rom_addr !== 8'h00 || pixel_on !== 1'b0) begin
                    n_fail++;
                    $display("FAIL outside_scan (%0d,%0d): addr=%h pon=%b want 00 0",
                             pixel_x, pixel_y, rom_addr, pixel_on);
                end
            end
        end
        video_on = 1'b0;
        probe(10'd274, 10'd22, a, p);
        video_on = 1'b1;
        n_checks++;
        if (a !== 8'h00 || p !== 1'b0) begin
            n_fail++;
            $display("FAIL video_off: addr=%h pon=%b want 00 0", a, p);
        end
    endtask

    task automatic test_convert;
        vec_t v[9];
        int cnt;
        logic [7:0] a;
        logic p;
        v = '{'{10'd256, 10'd16, 8'h40, 1'b0},
              '{10'd266, 10'd18, 8'h41, 1'b1},
              '{10'd256, 10'd32, 8'h48, 1'b1},
              '{10'd286, 10'd18, 8'h71, 1'b1},
              '{10'd280, 10'd18, 8'h71, 1'b0},
              '{10'd358, 10'd18, 8'h01, 1'b0},   // right tens 0 blanked
              '{10'd378, 10'd18, 8'h51, 1'b1},
              '{10'd380, 10'd18, 8'h51, 1'b0},
              '{10'd383, 10'd47, 8'h5F, 1'b1}};  // last pixel of last cell
        pulse_frame(7'd47, 7'd5);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (cnt != 7) begin
            n_fail++;
            $display("FAIL conv_47_5_busy: cycles=%0d want 7", cnt);
        end
        foreach (v[i]) begin
            probe(v[i].x, v[i].y, a, p);
            n_checks++;
            if (a !== v[i].a || p !== v[i].p) begin
                n_fail++;
                $display("FAIL conv_vec%0d: addr=%h pon=%b want %h %b", i, a, p, v[i].a, v[i].p);
            end
        end
    endtask

    task automatic test_latency;
        logic [7:0] a;
        logic p;
        probe(10'd100, 10'd100, a, p);
        @(negedge clk);
        pixel_x = 10'd266; pixel_y = 10'd18;
        @(posedge clk);
        #1;
        n_checks++;
        if (pixel_on !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_1cyc: pon=%b want 0", pixel_on);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (pixel_on !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_2cyc: pon=%b want 1", pixel_on);
        end
    endtask

    task automatic test_clamp;
        vec_t v[6];
        int cnt;
        logic [7:0] a;
        logic p;
        v = '{'{10'd256, 10'd18, 8'h91, 1'b0},
              '{10'd264, 10'd18, 8'h91, 1'b1},
              '{10'd266, 10'd18, 8'h91, 1'b0},
              '{10'd272, 10'd18, 8'h91, 1'b0},
              '{10'd352, 10'd18, 8'h91, 1'b0},
              '{10'd376, 10'd18, 8'h91, 1'b1}};
        pulse_frame(7'd120, 7'd99);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (cnt != 21) begin
            n_fail++;
            $display("FAIL clamp_busy: cycles=%0d want 21", cnt);
        end
        foreach (v[i]) begin
            probe(v[i].x, v[i].y, a, p);
            n_checks++;
            if (a !== v[i].a || p !== v[i].p) begin
                n_fail++;
                $display("FAIL clamp_vec%0d: addr=%h pon=%b want %h %b", i, a, p, v[i].a, v[i].p);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp;
        logic [7:0] a;
        logic p;
        // Display holds 99/99; watch the left tens cell address every cycle.
        pixel_x = 10'd256; pixel_y = 10'd16;
        pulse_frame(7'd40, 7'd0);
        for (int k = 0; k < 12; k++) begin
            exp = (k < 7) ? 8'h90 : 8'h40;
            n_checks++;
            if (rom_addr !== exp || busy !== (k < 7)) begin
                n_fail++;
                $display("FAIL midframe_k%0d: addr=%h busy=%b want %h %b", k, rom_addr, busy, exp, k < 7);
            end
            if (k == 2) begin
                score_left = 7'd13; frame_start = 1'b1;
            end else begin
                frame_start = 1'b0;
            end
            @(negedge clk);
        end
        probe(10'd272, 10'd18, a, p);
        n_checks++;
        if (a !== 8'h01) begin
            n_fail++;
            $display("FAIL midframe_lu: addr=%h want 01", a);
        end
        probe(10'd368, 10'd18, a, p);
        n_checks++;
        if (a !== 8'h01) begin
            n_fail++;
            $display("FAIL midframe_ru: addr=%h want 01", a);
        end
    endtask

    task automatic test_reset_midconv;
        int cnt;
        logic [7:0] a;
        logic p;
        probe(10'd266, 10'd18, a, p);
        n_checks++;
        if (a !== 8'h41 || p !== 1'b1) begin
            n_fail++;
            $display("FAIL prerst_vec: addr=%h pon=%b want 41 1", a, p);
        end
        pulse_frame(7'd47, 7'd5);
        repeat (5) @(negedge clk);   // now in CONV_R
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL prerst_busy: busy=%b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || pixel_on !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b pon=%b want 0 0", busy, pixel_on);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        probe(10'd266, 10'd18, a, p);
        n_checks++;
        if (a !== 8'h01 || p !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL postrst_lt: addr=%h pon=%b busy=%b want 01 0 0", a, p, busy);
        end
        probe(10'd274, 10'd22, a, p);
        n_checks++;
        if (a !== 8'h03 || p !== 1'b1) begin
            n_fail++;
            $display("FAIL postrst_lu: addr=%h pon=%b want 03 1", a, p);
        end
        pulse_frame(7'd47, 7'd5);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (cnt != 7) begin
            n_fail++;
            $display("FAIL restart_busy: cycles=%0d want 7", cnt);
        end
        probe(10'd256, 10'd16, a, p);
        n_checks++;
        if (a !== 8'h40) begin
            n_fail++;
            $display("FAIL restart_lt: addr=%h want 40", a);
        end
        probe(10'd378, 10'd18, a, p);
        n_checks++;
        if (a !== 8'h51 || p !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_ru: addr=%h pon=%b want 51 1", a, p);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_convert();
        test_latency();
        test_clamp();
        test_back_to_back();
        test_reset_midconv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
